mem_write_checker: RTL and testbench

- Synthesizable store-stream checker that sits beside top_pipe on the data-memory write port (memwrite/dataadr/writedata).
- Compares observed stores against a programmable table of NUM_CHECKS expected (address, data) pairs.
- Skips stores to a designated scratch address and enforces a cycle timeout.
- Reports done/pass/fail plus failure diagnostics; usable in simulation benches and on FPGA with result LEDs/UART.

---
 rtl/memchk_pkg.sv | 28 ++
 rtl/memchk_timer.sv | 34 +++
 rtl/mem_write_checker.sv | 202 ++++++++++++++++++++
 tb/tb_mem_write_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/memchk_pkg.sv
// Shared types and defaults for the store-stream checker (mem_write_checker).
package memchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic {
    MISMATCH = 1'b0,
    TIMEOUT  = 1'b1
  } fail_cause_t;

  localparam int unsigned DEF_IGNORE_ADDR = 32'd96;

  // Number of set bits; callers zero-extend narrower masks.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/memchk_timer.sv
// Saturating cycle counter; expired is high once the count reaches LIMIT-1.
module memchk_timer
  import memchk_pkg::*;
#(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_r;

  // count enabled cycles, holding at LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LAST);

endmodule

// File: rtl/mem_write_checker.sv
// Checks core stores against a table of expected (address, data) pairs.
// Define MEMCHK_UNORDERED_EN to accept the expected stores in any order.
module mem_write_checker
  import memchk_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_CHECKS     = 4,
  parameter int unsigned IGNORE_ADDR    = DEF_IGNORE_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              clear,
  input  logic                              memwrite,
  input  logic [ADDR_W-1:0]                 dataadr,
  input  logic [DATA_W-1:0]                 writedata,
  input  logic [NUM_CHECKS*ADDR_W-1:0]      exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]      exp_data,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic                              timeout,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   match_count,
  output logic [ADDR_W-1:0]                 fail_addr,
  output logic [DATA_W-1:0]                 fail_data
);

  localparam int CW = $clog2(NUM_CHECKS + 1);
  localparam logic [ADDR_W-1:0] IGN_A = ADDR_W'(IGNORE_ADDR);

  state_t            state_r, state_s;
  fail_cause_t       cause_r, cause_s;
  logic [CW-1:0]     cnt_r, cnt_s, cnt_inc_s;
  logic [ADDR_W-1:0] faddr_r, faddr_s;
  logic [DATA_W-1:0] fdata_r, fdata_s;
  logic              done_r, pass_r, fail_r, timeout_r;
  logic              expired_s, unknown_s, store_s, hit_s, complete_s;

  memchk_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clear || (state_r == IDLE)),
    .en      (state_r == RUN),
    .expired (expired_s)
  );

`ifndef SYNTHESIS
  assign unknown_s = $isunknown({memwrite, dataadr, writedata});
`else
  assign unknown_s = 1'b0;
`endif

  // An undefined strobe/bus is treated as a store that can never match.
  assign store_s = unknown_s || (memwrite && (dataadr != IGN_A));

`ifdef MEMCHK_UNORDERED_EN
  logic [NUM_CHECKS-1:0] mask_r, onehot_s, mask_upd_s;

  // pick the lowest unmatched entry equal to this store
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if ((onehot_s == '0) && !mask_r[i] &&
          (dataadr == exp_addr[i*ADDR_W +: ADDR_W]) &&
          (writedata == exp_data[i*DATA_W +: DATA_W])) begin
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = onehot_s[i];
      end
    end
    mask_upd_s = mask_r | onehot_s;
    hit_s      = !unknown_s && (onehot_s != '0);
    cnt_inc_s  = CW'(popcount(64'(mask_upd_s)));
    complete_s = &mask_upd_s;
  end

  // matched-entry mask, only meaningful while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= '0;
    end else if (clear || (state_r != RUN)) begin
      mask_r <= '0;
    end else if (store_s && hit_s) begin
      mask_r <= mask_upd_s;
    end else begin
      mask_r <= mask_r;
    end
  end
`else
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  // compare against the entry indexed by the running match count
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (cnt_r == CW'(i)) begin
        sel_addr_s = exp_addr[i*ADDR_W +: ADDR_W];
        sel_data_s = exp_data[i*DATA_W +: DATA_W];
      end else begin
        sel_addr_s = sel_addr_s;
        sel_data_s = sel_data_s;
      end
    end
    hit_s      = !unknown_s && (dataadr == sel_addr_s) && (writedata == sel_data_s);
    cnt_inc_s  = cnt_r + CW'(1);
    complete_s = (cnt_inc_s == CW'(NUM_CHECKS));
  end
`endif

  // next-state and result capture; a completing match beats the timeout
  always_comb begin
    state_s = state_r;
    cause_s = cause_r;
    cnt_s   = cnt_r;
    faddr_s = faddr_r;
    fdata_s = fdata_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (store_s && hit_s) begin
          cnt_s = cnt_inc_s;
          if (complete_s) begin
            state_s = PASS;
          end else if (expired_s) begin
            state_s = FAIL;
            cause_s = TIMEOUT;
          end else begin
            state_s = RUN;
          end
        end else if (store_s) begin
          state_s = FAIL;
          cause_s = MISMATCH;
          faddr_s = dataadr;
          fdata_s = writedata;
        end else if (expired_s) begin
          state_s = FAIL;
          cause_s = TIMEOUT;
          faddr_s = '0;
          fdata_s = '0;
        end else begin
          state_s = RUN;
        end
      end
      PASS:    state_s = PASS;
      FAIL:    state_s = FAIL;
      default: state_s = IDLE;
    endcase
    if (clear) begin
      state_s = IDLE;
      cause_s = MISMATCH;
      cnt_s   = '0;
      faddr_s = '0;
      fdata_s = '0;
    end else begin
      state_s = state_s;
    end
  end

  // state and registered result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cause_r   <= MISMATCH;
      cnt_r     <= '0;
      faddr_r   <= '0;
      fdata_r   <= '0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cause_r   <= cause_s;
      cnt_r     <= cnt_s;
      faddr_r   <= faddr_s;
      fdata_r   <= fdata_s;
      done_r    <= (state_s == PASS) || (state_s == FAIL);
      pass_r    <= (state_s == PASS);
      fail_r    <= (state_s == FAIL);
      timeout_r <= (state_s == FAIL) && (cause_s == TIMEOUT);
    end
  end

  assign done        = done_r;
  assign pass        = pass_r;
  assign fail        = fail_r;
  assign timeout     = timeout_r;
  assign match_count = cnt_r;
  assign fail_addr   = faddr_r;
  assign fail_data   = fdata_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (TIMEOUT_CYCLES=50); honours MEMCHK_UNORDERED_EN.
module tb_mem_write_checker;

  typedef struct packed {
    logic        done, pass, fail, tmo;
    logic [2:0]  cnt;
    logic [31:0] fa, fd;
  } out_t;

  typedef struct packed {
    logic        clr, st, mw;
    logic [31:0] a, d;
    out_t        e;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, clear = 1'b0, memwrite = 1'b0;
  logic [31:0]  dataadr = 32'd0, writedata = 32'd0;
  logic [127:0] exp_addr = {32'd112, 32'd108, 32'd104, 32'd100};
  logic [127:0] exp_data = {32'd0, 32'd1, 32'd7, 32'd25};
  logic         done, pass, fail, timeout;
  logic [2:0]   match_count;
  logic [31:0]  fail_addr, fail_data;

  int total = 0;
  int bad = 0;
  vec_t vt[17];

  mem_write_checker #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_count(match_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  function automatic out_t o(input logic dn, input logic p, input logic f, input logic t,
                             input int c, input int fa, input int fd);
    return '{done: dn, pass: p, fail: f, tmo: t, cnt: 3'(c), fa: 32'(fa), fd: 32'(fd)};
  endfunction

  function automatic vec_t v(input logic c, input logic s, input logic m,
                             input int a, input int d, input out_t e);
    return '{clr: c, st: s, mw: m, a: 32'(a), d: 32'(d), e: e};
  endfunction

  task automatic cyc(input logic c, input logic s, input logic m, input int a, input int d);
    clear = c; start = s; memwrite = m; dataadr = 32'(a); writedata = 32'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = '{done: done, pass: pass, fail: fail, tmo: timeout, cnt: match_count,
          fa: fail_addr, fd: fail_data};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got done=%0b pass=%0b fail=%0b tmo=%0b cnt=%0d fa=%0d fd=%0d want done=%0b pass=%0b fail=%0b tmo=%0b cnt=%0d fa=%0d fd=%0d",
               nm, a.done, a.pass, a.fail, a.tmo, a.cnt, a.fa, a.fd,
               e.done, e.pass, e.fail, e.tmo, e.cnt, e.fa, e.fd);
    end
  endtask

  // clear, start, then n idle RUN cycles
  task automatic run_idle(input int n);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    vt[0]  = v(0, 0, 0,   0,  0, o(0, 0, 0, 0, 0,   0, 0));
    vt[1]  = v(0, 1, 0,   0,  0, o(0, 0, 0, 0, 0,   0, 0));
    vt[2]  = v(0, 0, 1,  96,  3, o(0, 0, 0, 0, 0,   0, 0));
    vt[3]  = v(0, 0, 1, 100, 25, o(0, 0, 0, 0, 1,   0, 0));
    vt[4]  = v(0, 0, 1,  96,  9, o(0, 0, 0, 0, 1,   0, 0));
    vt[5]  = v(0, 0, 0, 104,  8, o(0, 0, 0, 0, 1,   0, 0));
    vt[6]  = v(0, 0, 1, 104,  7, o(0, 0, 0, 0, 2,   0, 0));
    vt[7]  = v(0, 0, 1, 108,  1, o(0, 0, 0, 0, 3,   0, 0));
    vt[8]  = v(0, 0, 1, 112,  0, o(1, 1, 0, 0, 4,   0, 0));
    vt[9]  = v(0, 0, 1,   5,  5, o(1, 1, 0, 0, 4,   0, 0));
    vt[10] = v(0, 1, 0,   0,  0, o(1, 1, 0, 0, 4,   0, 0));
    vt[11] = v(1, 1, 0,   0,  0, o(0, 0, 0, 0, 0,   0, 0));
    vt[12] = v(0, 1, 0,   0,  0, o(0, 0, 0, 0, 0,   0, 0));
    vt[13] = v(0, 0, 1, 100, 25, o(0, 0, 0, 0, 1,   0, 0));
    vt[14] = v(0, 0, 1, 104,  8, o(1, 0, 1, 0, 1, 104, 8));
    vt[15] = v(0, 0, 1, 108,  1, o(1, 0, 1, 0, 1, 104, 8));
    vt[16] = v(1, 0, 0,   0,  0, o(0, 0, 0, 0, 0,   0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", o(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].clr, vt[i].st, vt[i].mw, int'(vt[i].a), int'(vt[i].d));
      chk($sformatf("vec%0d", i), vt[i].e);
    end

    // timeout lands on the 50th RUN edge
    run_idle(49);
    chk("tmo_edge49", o(0, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    chk("tmo_edge50", o(1, 0, 1, 1, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b1, 100, 25);
    chk("tmo_sticky", o(1, 0, 1, 1, 0, 0, 0));

    // completing match on the expiry edge wins
    run_idle(46);
    cyc(1'b0, 1'b0, 1'b1, 100, 25);
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    cyc(1'b0, 1'b0, 1'b1, 108, 1);
    chk("late_cnt3", o(0, 0, 0, 0, 3, 0, 0));
    cyc(1'b0, 1'b0, 1'b1, 112, 0);
    chk("match_beats_tmo", o(1, 1, 0, 0, 4, 0, 0));

    // mismatch on the expiry edge reports the store
    run_idle(49);
    cyc(1'b0, 1'b0, 1'b1, 100, 99);
    chk("mismatch_at_tmo", o(1, 0, 1, 0, 0, 100, 99));

    // async reset mid-RUN
    run_idle(0);
    cyc(1'b0, 1'b0, 1'b1, 100, 25);
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    chk("pre_reset_cnt2", o(0, 0, 0, 0, 2, 0, 0));
    #2 reset = 1'b0;
    #1 chk("async_reset", o(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 100, 25);
    chk("post_reset_idx0", o(0, 0, 0, 0, 1, 0, 0));
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    cyc(1'b0, 1'b0, 1'b1, 108, 1);
    cyc(1'b0, 1'b0, 1'b1, 112, 0);
    chk("post_reset_pass", o(1, 1, 0, 0, 4, 0, 0));

`ifdef MEMCHK_UNORDERED_EN
    run_idle(0);
    cyc(1'b0, 1'b0, 1'b1, 112, 0);
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    cyc(1'b0, 1'b0, 1'b1, 100, 25);
    chk("unord_cnt3", o(0, 0, 0, 0, 3, 0, 0));
    cyc(1'b0, 1'b0, 1'b1, 108, 1);
    chk("unord_pass", o(1, 1, 0, 0, 4, 0, 0));
    run_idle(0);
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    cyc(1'b0, 1'b0, 1'b1, 112, 0);
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    chk("unord_repeat", o(1, 0, 1, 0, 2, 104, 7));
`else
    run_idle(0);
    cyc(1'b0, 1'b0, 1'b1, 104, 7);
    chk("ord_out_of_order", o(1, 0, 1, 0, 0, 104, 7));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
